// File: rtl/mux_4.sv
// Next-PC select: picks the branch target or PC+1, exposing both a zero-latency
// and a registered copy, plus a saturating count of taken-branch captures.
module mux_4 #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] PC1,
   input  logic [WIDTH-1:0] rULA2,
   input  logic             pAND,
   input  logic             en,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] out_comb,
   output logic             out_valid,
   output logic             sel_q,
   output logic [7:0]       taken_cnt
);

   logic [WIDTH-1:0] out_reg, out_next;
   logic             valid_reg, valid_next;
   logic             sel_reg, sel_next;
   logic [7:0]       cnt_reg, cnt_next;

   // Per-bit select keeps the output a bit-exact copy of the chosen candidate.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_sel
         assign out_comb[gi] = pAND ? rULA2[gi] : PC1[gi];
      end
   endgenerate

   always_comb begin
      out_next   = out_reg;
      valid_next = valid_reg;
      sel_next   = sel_reg;
      cnt_next   = cnt_reg;
      if (en) begin
         out_next   = out_comb;
         valid_next = 1'b1;
         sel_next   = pAND;
         if (pAND && (cnt_reg != 8'hFF))
            cnt_next = cnt_reg + 8'd1;
      end
   end

   // Reset wins over en; out_comb stays outside the reset path.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_reg   <= '0;
         valid_reg <= 1'b0;
         sel_reg   <= 1'b0;
         cnt_reg   <= 8'd0;
      end else begin
         out_reg   <= out_next;
         valid_reg <= valid_next;
         sel_reg   <= sel_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign out       = out_reg;
   assign out_valid = valid_reg;
   assign sel_q     = sel_reg;
   assign taken_cnt = cnt_reg;

endmodule

// File: tb/tb_mux_4.sv
// Bench for mux_4: directed scenarios plus randomized traffic against a
// behavioural model of the selected-value register and taken counter.
module tb_mux_4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] PC1, rULA2;
   logic       pAND, en;
   logic [7:0] out, out_comb, taken_cnt;
   logic       out_valid, sel_q;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_out;
   logic       m_sel, m_valid;
   int         m_cnt;

   mux_4 #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .PC1(PC1), .rULA2(rULA2), .pAND(pAND), .en(en),
      .out(out), .out_comb(out_comb), .out_valid(out_valid), .sel_q(sel_q),
      .taken_cnt(taken_cnt)
   );

   always #5 clk = ~clk;

   // Advance the model by one edge using the current inputs, then step the clock.
   task automatic tick();
      if (!rst_n) begin
         m_out = 8'h00; m_sel = 1'b0; m_valid = 1'b0; m_cnt = 0;
      end else if (en) begin
         m_out   = pAND ? rULA2 : PC1;
         m_sel   = pAND;
         m_valid = 1'b1;
         if (pAND) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b0; pAND = 1'b0; PC1 = 8'h5A; rULA2 = 8'hA5;
      tick();
      checks++;
      if ({out, sel_q, out_valid, taken_cnt} !== {8'h00, 1'b0, 1'b0, 8'h00}) begin
         errors++;
         $display("FAIL reset: out=%h sel_q=%b valid=%b cnt=%0d, want 00 0 0 0",
                  out, sel_q, out_valid, taken_cnt);
      end
      $display("reset: out=%h sel_q=%b valid=%b cnt=%0d", out, sel_q, out_valid, taken_cnt);
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      PC1 = 8'h11; rULA2 = 8'h0D; pAND = 1'b0; en = 1'b1; #1;
      checks++;
      if (out_comb !== 8'h11) begin
         errors++; $display("FAIL seq_comb: out_comb=%h want 11", out_comb);
      end
      tick();
      checks++;
      if ({out, sel_q, out_valid, taken_cnt} !== {8'h11, 1'b0, 1'b1, 8'd0}) begin
         errors++;
         $display("FAIL seq_capture: out=%h sel_q=%b valid=%b cnt=%0d, want 11 0 1 0",
                  out, sel_q, out_valid, taken_cnt);
      end
      $display("seq capture: out=%h sel_q=%b cnt=%0d", out, sel_q, taken_cnt);
      pAND = 1'b1; #1;
      checks++;
      if (out_comb !== 8'h0D) begin
         errors++; $display("FAIL branch_comb: out_comb=%h want 0d", out_comb);
      end
      tick();
      checks++;
      if ({out, sel_q, out_valid, taken_cnt} !== {8'h0D, 1'b1, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL branch_capture: out=%h sel_q=%b valid=%b cnt=%0d, want 0d 1 1 1",
                  out, sel_q, out_valid, taken_cnt);
      end
      $display("branch capture: out=%h sel_q=%b cnt=%0d", out, sel_q, taken_cnt);
   endtask

   task automatic test_hold();
      en = 1'b0; pAND = 1'b0; PC1 = 8'hFF; rULA2 = 8'hAA; #1;
      checks++;
      if (out_comb !== 8'hFF || out !== 8'h0D) begin
         errors++; $display("FAIL hold_comb0: out_comb=%h out=%h want ff 0d", out_comb, out);
      end
      pAND = 1'b1; #1;
      checks++;
      if (out_comb !== 8'hAA || out !== 8'h0D || sel_q !== 1'b1) begin
         errors++; $display("FAIL hold_comb1: out_comb=%h out=%h sel_q=%b want aa 0d 1",
                            out_comb, out, sel_q);
      end
      for (int i = 0; i < 4; i++) begin
         pAND = ~pAND;
         tick();
         checks++;
         if ({out, sel_q, out_valid, taken_cnt} !== {8'h0D, 1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL hold_edge%0d: out=%h sel_q=%b valid=%b cnt=%0d, want 0d 1 1 1",
                     i, out, sel_q, out_valid, taken_cnt);
         end
         $display("hold edge %0d: out=%h sel_q=%b cnt=%0d", i, out, sel_q, taken_cnt);
      end
   endtask

   task automatic test_saturate();
      pAND = 1'b1; en = 1'b1;
      for (int i = 0; i < 300; i++) begin
         PC1 = 8'($urandom); rULA2 = 8'($urandom);
         tick();
         checks++;
         if (taken_cnt !== 8'(m_cnt) || out !== m_out) begin
            errors++;
            $display("FAIL saturate%0d: cnt=%0d out=%h want %0d %h", i, taken_cnt, out, m_cnt, m_out);
         end
      end
      checks++;
      if (taken_cnt !== 8'd255) begin
         errors++; $display("FAIL saturate_final: cnt=%0d want 255", taken_cnt);
      end
      $display("saturate: cnt=%0d after 300 taken captures", taken_cnt);
   endtask

   task automatic test_reset_priority();
      rst_n = 1'b0; en = 1'b1; pAND = 1'b1; PC1 = 8'h33; rULA2 = 8'hCC; #1;
      checks++;
      if (out_comb !== 8'hCC) begin
         errors++; $display("FAIL reset_comb: out_comb=%h want cc", out_comb);
      end
      tick();
      checks++;
      if ({out, sel_q, out_valid, taken_cnt} !== {8'h00, 1'b0, 1'b0, 8'd0}) begin
         errors++;
         $display("FAIL reset_prio: out=%h sel_q=%b valid=%b cnt=%0d, want 00 0 0 0",
                  out, sel_q, out_valid, taken_cnt);
      end
      $display("reset priority: out=%h cnt=%0d", out, taken_cnt);
      rst_n = 1'b1;
      tick();
      checks++;
      if ({out, sel_q, out_valid, taken_cnt} !== {8'hCC, 1'b1, 1'b1, 8'd1}) begin
         errors++;
         $display("FAIL post_reset: out=%h sel_q=%b valid=%b cnt=%0d, want cc 1 1 1",
                  out, sel_q, out_valid, taken_cnt);
      end
      $display("first capture after reset: out=%h cnt=%0d", out, taken_cnt);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         PC1   = 8'($urandom);
         rULA2 = 8'($urandom);
         pAND  = 1'($urandom);
         en    = ($urandom_range(3) != 0);
         rst_n = ($urandom_range(15) != 0);
         #1;
         checks++;
         if (out_comb !== (pAND ? rULA2 : PC1)) begin
            errors++; $display("FAIL rand_comb%0d: out_comb=%h want %h", i, out_comb,
                               pAND ? rULA2 : PC1);
         end
         tick();
         checks++;
         if ({out, sel_q, out_valid, taken_cnt} !== {m_out, m_sel, m_valid, 8'(m_cnt)}) begin
            errors++;
            $display("FAIL rand%0d: out=%h sel_q=%b valid=%b cnt=%0d, want %h %b %b %0d",
                     i, out, sel_q, out_valid, taken_cnt, m_out, m_sel, m_valid, m_cnt);
         end
      end
      $display("random: 400 cycles, last out=%h cnt=%0d", out, taken_cnt);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b0; pAND = 1'b0; PC1 = 8'h00; rULA2 = 8'h00;
      m_out = 8'h00; m_sel = 1'b0; m_valid = 1'b0; m_cnt = 0;
      @(posedge clk); #1;
      test_reset();
      test_directed();
      test_hold();
      test_reset();
      test_saturate();
      test_reset_priority();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
